hilo_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide responder that owns the architectural HI/LO registers.
- The ALU/decode stage issues MULT, MULTU, DIV or DIVU with a start pulse, then stalls on busy.
- The unit iterates for 32 cycles, commits HI/LO and pulses done.
- It also serves MTHI/MTLO writes and continuously drives HI/LO to the MFHI/MFLO read path.

---
 rtl/mips_muldiv_pkg.sv | 18 +
 rtl/muldiv_step.sv | 32 +++
 rtl/hilo_muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state type and iteration count.
package mips_muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned shift-add multiplier or
// restoring divider operating on a packed {upper, lower} accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 isDiv_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     operand_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    // Multiply keeps the multiplier in the low half and shifts the carry-out
    // of the partial sum back in; divide shifts the dividend up into the
    // remainder half and records a quotient bit in the vacated LSB.
    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        trial = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, operand_i};
        if (isDiv_i) begin
            if (!trial[WIDTH]) begin
                acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO
// registers; fixed 34-edge latency from start to done.
module hilo_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_e        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     operand_q, operand_d;
    logic [1:0]           op_q, op_d;
    logic                 signQuot_q, signQuot_d;
    logic                 signRem_q, signRem_d;
    logic                 divZero_q, divZero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [2*WIDTH-1:0]   stepAcc;
    logic [2*WIDTH-1:0]   result;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .isDiv_i   (op_q[1]),
        .acc_i     (acc_q),
        .operand_i (operand_q),
        .acc_o     (stepAcc)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        operand_d  = operand_q;
        op_d       = op_q;
        signQuot_d = signQuot_q;
        signRem_d  = signRem_q;
        divZero_d  = divZero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result     = acc_q;
        magA       = (op[0] && a[WIDTH-1]) ? -a : a;
        magB       = (op[0] && b[WIDTH-1]) ? -b : b;

        unique case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    // The iterating value sits in the low accumulator half; the
                    // other magnitude is held constant as the step operand.
                    op_d       = op;
                    acc_d      = {{WIDTH{1'b0}}, (op[1] ? magA : magB)};
                    operand_d  = op[1] ? magB : magA;
                    signQuot_d = a[WIDTH-1] ^ b[WIDTH-1];
                    signRem_d  = a[WIDTH-1];
                    divZero_d  = (b == '0);
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = stepAcc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MULDIV_ITER - 1)) state_d = S_FIXUP;
            end
            S_FIXUP: begin
                // Divide-by-zero keeps the all-ones quotient, but the remainder
                // still takes the dividend's sign so HI returns the raw dividend.
                if (op_q == OP_MULT && signQuot_q) result = -acc_q;
                if (op_q == OP_DIV) begin
                    if (signQuot_q && !divZero_q) result[WIDTH-1:0] = -acc_q[WIDTH-1:0];
                    if (signRem_q) result[2*WIDTH-1:WIDTH] = -acc_q[2*WIDTH-1:WIDTH];
                end
                hi_d    = result[2*WIDTH-1:WIDTH];
                lo_d    = result[WIDTH-1:0];
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            operand_q  <= '0;
            op_q       <= OP_MULTU;
            signQuot_q <= 1'b0;
            signRem_q  <= 1'b0;
            divZero_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            operand_q  <= operand_d;
            op_q       <= op_d;
            signQuot_q <= signQuot_d;
            signRem_q  <= signRem_d;
            divZero_q  <= divZero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed corner cases plus
// randomized ops checked against an arithmetic reference model.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectorCount = 0;
    int missCount   = 0;

    hilo_muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Watchdog so a stuck design still ends the run with a visible failure.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural result {HI, LO} computed with plain integer arithmetic.
    function automatic logic [63:0] refModel(input logic [1:0] opIn, input logic [31:0] aIn,
                                              input logic [31:0] bIn);
        longint sa, sb, q, m;
        logic [63:0] r;
        sa = longint'($signed(aIn));
        sb = longint'($signed(bIn));
        case (opIn)
            2'b00: r = {32'b0, aIn} * {32'b0, bIn};
            2'b01: r = 64'(sa * sb);
            2'b10: r = (bIn == 0) ? {aIn, 32'hFFFFFFFF} : {aIn % bIn, aIn / bIn};
            default: begin
                if (bIn == 0) begin
                    r = {aIn, 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    // Issues one op from the current (post-edge) time and returns in the done cycle.
    task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] aIn,
                                 input logic [31:0] bIn, input bit disturb);
        logic [63:0] exp;
        int edges;
        bit busyGap;
        exp   = refModel(opIn, aIn, bIn);
        start = 1'b1;
        op    = opIn;
        a     = aIn;
        b     = bIn;
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        checkOutput("busy_e0", {63'b0, busy}, 64'd1);
        checkOutput("done_e0", {63'b0, done}, 64'd0);
        edges   = 0;
        busyGap = 0;
        while (!done && edges < 40) begin
            if (disturb && edges == 4) begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = $urandom;
                start = 1'b1;
                op    = 2'($urandom_range(0, 3));
            end else begin
                hi_we = 1'b0;
                lo_we = 1'b0;
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
            if (!done && !busy) busyGap = 1;
        end
        hi_we = 1'b0;
        lo_we = 1'b0;
        start = 1'b0;
        checkOutput($sformatf("latency op%0d", opIn), 64'(edges), 64'd33);
        checkOutput("busy_held", {63'b0, busyGap}, 64'd0);
        checkOutput("busy_at_done", {63'b0, busy}, 64'd0);
        checkOutput($sformatf("hi op%0d a=%h b=%h", opIn, aIn, bIn), {32'b0, hi}, {32'b0, exp[63:32]});
        checkOutput($sformatf("lo op%0d a=%h b=%h", opIn, aIn, bIn), {32'b0, lo}, {32'b0, exp[31:0]});
    endtask

    task automatic stepAndCheckDoneFell();
        @(posedge clk); #1;
        checkOutput("done_pulse", {63'b0, done}, 64'd0);
    endtask

    initial begin
        logic [1:0]  rOp;
        logic [31:0] rA, rB;
        bit sawDone;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hi", {32'b0, hi}, 64'd0);
        checkOutput("reset_lo", {32'b0, lo}, 64'd0);
        checkOutput("reset_busy", {63'b0, busy}, 64'd0);
        checkOutput("reset_done", {63'b0, done}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // MTHI / MTLO in IDLE
        hi_we = 1'b1; wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        hi_we = 1'b0;
        checkOutput("mthi", {32'b0, hi}, 64'hAAAA5555);
        lo_we = 1'b1; wdata = 32'h12345678;
        @(posedge clk); #1;
        lo_we = 1'b0;
        checkOutput("mtlo", {32'b0, lo}, 64'h12345678);
        checkOutput("mtlo_hi_kept", {32'b0, hi}, 64'hAAAA5555);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F0F0F;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        checkOutput("mthilo_hi", {32'b0, hi}, 64'h0F0F0F0F);
        checkOutput("mthilo_lo", {32'b0, lo}, 64'h0F0F0F0F);

        // Directed operations
        applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0); stepAndCheckDoneFell();
        applyStimulus(2'b01, 32'hFFFFFFFD, 32'd5, 0);        stepAndCheckDoneFell();
        applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2, 0);        stepAndCheckDoneFell();
        applyStimulus(2'b10, 32'd100, 32'd7, 0);             stepAndCheckDoneFell();
        applyStimulus(2'b10, 32'h1234, 32'd0, 0);            stepAndCheckDoneFell();
        applyStimulus(2'b11, 32'hFFFFFF00, 32'd0, 0);        stepAndCheckDoneFell();
        applyStimulus(2'b11, 32'h80000000, 32'hFFFFFFFF, 0); stepAndCheckDoneFell();
        applyStimulus(2'b01, 32'h80000000, 32'h80000000, 0); stepAndCheckDoneFell();
        applyStimulus(2'b11, 32'd7, 32'hFFFFFFFE, 0);        stepAndCheckDoneFell();

        // Writes and a second start while busy are ignored
        applyStimulus(2'b01, 32'd12345, 32'hFFFFFF85, 1);    stepAndCheckDoneFell();

        // Reset in the middle of a multiply aborts it
        start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_hi", {32'b0, hi}, 64'd0);
        checkOutput("abort_lo", {32'b0, lo}, 64'd0);
        checkOutput("abort_busy", {63'b0, busy}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        sawDone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) sawDone = 1;
        end
        checkOutput("abort_no_done", {63'b0, sawDone}, 64'd0);
        checkOutput("abort_lo_kept", {32'b0, lo}, 64'd0);
        applyStimulus(2'b10, 32'd9, 32'd4, 0);

        // Back-to-back: the next start is asserted in the done cycle
        applyStimulus(2'b00, 32'd1000, 32'd3000, 0);
        applyStimulus(2'b11, 32'hFFFF0000, 32'd3, 0);
        stepAndCheckDoneFell();

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = $urandom;
            rB  = $urandom;
            case ($urandom_range(0, 7))
                0: rB = 32'd0;
                1: rB = $urandom_range(1, 15);
                2: rB = 32'hFFFFFFFF;
                3: rA = 32'h80000000;
                default: ;
            endcase
            applyStimulus(rOp, rA, rB, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 0) stepAndCheckDoneFell();
        end
        stepAndCheckDoneFell();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
